// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port
// valid/ready memory. One memory transaction per grant; registered outputs;
// timeout with error pulse if the memory never answers.
module mem_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  req1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DONE} state_t;

  state_t                r_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [CW-1:0]         r_cnt;

  state_t                w_state_nxt;
  logic                  w_grant_nxt;
  logic                  w_last_grant_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_pick;
  logic                  w_mem_valid_nxt;
  logic                  w_mem_wr_rd_nxt;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [WIDTH-1:0]      w_mem_wdata_nxt;
  logic                  w_ready0_nxt;
  logic                  w_ready1_nxt;
  logic                  w_err0_nxt;
  logic                  w_err1_nxt;
  logic [WIDTH-1:0]      w_rdata0_nxt;
  logic [WIDTH-1:0]      w_rdata1_nxt;

  // Round-robin pick: req1 wins if alone, or on a tie when req0 was served last
  assign w_pick = req1_valid_i & (~req0_valid_i | ~r_last_grant);

  // Next-state and next-output computation; every output is registered below
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_mem_valid_nxt  = 1'b0;
    w_mem_wr_rd_nxt  = mem_wr_rd_o;
    w_mem_addr_nxt   = mem_addr_o;
    w_mem_wdata_nxt  = mem_wdata_o;
    w_ready0_nxt     = 1'b0;
    w_ready1_nxt     = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_rdata0_nxt     = req0_rdata_o;
    w_rdata1_nxt     = req1_rdata_o;
    unique case (r_state)
      S_IDLE: begin
        if (req0_valid_i | req1_valid_i) begin
          w_state_nxt      = S_ISSUE;
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
          w_mem_valid_nxt  = 1'b1;
          w_mem_wr_rd_nxt  = w_pick ? req1_wr_rd_i : req0_wr_rd_i;
          w_mem_addr_nxt   = w_pick ? req1_addr_i  : req0_addr_i;
          w_mem_wdata_nxt  = w_pick ? req1_wdata_i : req0_wdata_i;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_RESP;
        w_cnt_nxt   = '0;
      end
      S_RESP: begin
        if (mem_ready_i) begin
          w_state_nxt = S_DONE;
          if (r_grant) begin
            w_ready1_nxt = 1'b1;
            if (!mem_wr_rd_o) w_rdata1_nxt = mem_rdata_i;
          end else begin
            w_ready0_nxt = 1'b1;
            if (!mem_wr_rd_o) w_rdata0_nxt = mem_rdata_i;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          if (r_grant) begin
            w_ready1_nxt = 1'b1;
            w_err1_nxt   = 1'b1;
            w_rdata1_nxt = '0;
          end else begin
            w_ready0_nxt = 1'b1;
            w_err0_nxt   = 1'b1;
            w_rdata0_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any transaction in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      mem_valid_o  <= 1'b0;
      mem_wr_rd_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      req0_ready_o <= 1'b0;
      req1_ready_o <= 1'b0;
      req0_err_o   <= 1'b0;
      req1_err_o   <= 1'b0;
      req0_rdata_o <= '0;
      req1_rdata_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      mem_valid_o  <= w_mem_valid_nxt;
      mem_wr_rd_o  <= w_mem_wr_rd_nxt;
      mem_addr_o   <= w_mem_addr_nxt;
      mem_wdata_o  <= w_mem_wdata_nxt;
      req0_ready_o <= w_ready0_nxt;
      req1_ready_o <= w_ready1_nxt;
      req0_err_o   <= w_err0_nxt;
      req1_err_o   <= w_err1_nxt;
      req0_rdata_o <= w_rdata0_nxt;
      req1_rdata_o <= w_rdata1_nxt;
      busy_o       <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
